elevator_status_encoder: RTL and testbench
==========================================

Name: elevator_status_encoder

Overview:
- Elevator car controller that produces the 2-bit status code (Q1,Q0) consumed by the status display decoder, plus motor and door commands.
- Latches floor calls, runs a directional (SCAN) state machine, times inter-floor travel and door dwell, and handles emergency stop.
- Sits between the call-button inputs and the display/actuator outputs.

Parameters:
- FLOORS, 4, number of floors (2..16)
- FLOOR_W, 2, width of floor index; must satisfy 2**FLOOR_W >= FLOORS
- TRAVEL_CYCLES, 8, clock cycles to move one floor (>=2)
- DOOR_CYCLES, 6, clock cycles the door stays open (>=2)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- call  in  FLOORS  per-floor call request; sampled each cycle, may be a 1-cycle pulse
- emerg  in  1  emergency stop, level-sensitive
- Q1  out  1  status code MSB
- Q0  out  1  status code LSB
- motor_up  out  1  drive car upward
- motor_down  out  1  drive car downward
- door_open  out  1  door open command
- floor  out  FLOOR_W  last floor reached
- pending  out  FLOORS  latched, unserved requests

Behaviour:
- One clock; reset is synchronous and active-high. All outputs are registered.
- Reset values: state IDLE, floor=0, pending=0, direction preference=up, Q1Q0=00, motor_up=0, motor_down=0, door_open=0, counters=0.
- Status code: IDLE or DOOR=00, MOVE_UP=01, MOVE_DOWN=10, EMERG=11. Outputs update on the same edge as the state.
- Request latch: pending[i] <= pending[i] | call[i] every cycle except in EMERG. Serving a floor clears its bit on the edge that enters DOOR; a call for that floor on that same edge is absorbed (served).
- Let req = pending | call. Define above = any req bit > floor and below = any req bit < floor.
- IDLE:
  - req[floor]: go to DOOR.
  - Else if above and below both set: take the direction preference.
  - Else if only above: MOVE_UP. If only below: MOVE_DOWN.
  - Else stay in IDLE.
  - Decision is made on the edge that samples the call, so latency is 0 cycles after the call edge.
- MOVE_UP / MOVE_DOWN:
  - motor_up or motor_down=1 (never both). Travel counter counts TRAVEL_CYCLES cycles.
  - On the last cycle, floor increments or decrements and the counter reloads.
  - Then: if req[new floor], go to DOOR. Else if requests remain further in the same direction, keep moving. Else go to IDLE.
  - The direction preference is set to the current direction while moving.
  - Floor saturates at 0 and FLOORS-1; no wrap. Requests at the current floor made after departure stay pending.
- DOOR:
  - door_open=1 and motors=0 for DOOR_CYCLES cycles, then IDLE.
  - door_open is never 1 while either motor is 1.
- EMERG:
  - emerg=1 in any state forces EMERG on the next edge. Motors=0, door_open=0, pending cleared, calls ignored, travel and door counters cleared.
  - When emerg=0, go to IDLE on the next edge. floor holds the last floor reached, and the car is treated as located there.
- emerg has priority over every other transition. rst has priority over emerg.
- rst mid-motion or mid-door returns all outputs to reset values on the next edge.

Optional Feature:
- Macro: ELEVATOR_DOOR_REOPEN_EN.
- Defined: a call for the current floor while in DOOR reloads the door counter, so dwell restarts at DOOR_CYCLES, and the call is absorbed without setting pending.
- Undefined: such a call sets pending[floor]. After the door closes, IDLE re-enters DOOR for a second dwell.

Test Plan:
- Reset, then call=0100 pulse for 1 cycle at floor 0 -> Q1Q0=01 on the next edge. motor_up=1 for 16 cycles and floor steps 1 then 2. Then door_open=1 for 6 cycles with Q1Q0=00, then IDLE with pending=0000.
- At floor 2 in IDLE, call=1001 simultaneously, preference up -> MOVE_UP to floor 3, DOOR, then MOVE_DOWN with Q1Q0=10 through floors 2 and 1 to floor 0, then DOOR.
- Call for the current floor in IDLE -> DOOR on the next edge, no motor activity, pending bit never observed set.
- emerg=1 for 3 cycles mid-travel between floors 1 and 2 -> Q1Q0=11, motors=0, pending=0, calls during EMERG ignored. After release: IDLE at floor 1.
- rst asserted during DOOR -> next edge all outputs at reset values, floor=0.
- With and without ELEVATOR_DOOR_REOPEN_EN: current-floor call on the 4th DOOR cycle -> with the macro, door_open lasts 4+6 cycles total. Without it, one 6-cycle dwell, 1 IDLE cycle, then a second 6-cycle dwell.

Source files
------------

// File: rtl/elevator_status_encoder_if.sv
// Call/emergency inputs and status/actuator outputs of the elevator car controller.
// The master side drives calls and emergency; the slave side is the controller itself.
interface elevator_status_encoder_if #(
  parameter int FLOORS  = 4,
  parameter int FLOOR_W = 2
);
  logic [FLOORS-1:0]  call;
  logic               emerg;
  logic               Q1;
  logic               Q0;
  logic               motor_up;
  logic               motor_down;
  logic               door_open;
  logic [FLOOR_W-1:0] floor;
  logic [FLOORS-1:0]  pending;

  modport master (
    output call, emerg,
    input  Q1, Q0, motor_up, motor_down, door_open, floor, pending
  );

  modport slave (
    input  call, emerg,
    output Q1, Q0, motor_up, motor_down, door_open, floor, pending
  );
endinterface

// File: rtl/elevator_status_encoder.sv
// SCAN elevator controller producing the 2-bit status code plus motor/door commands.
// Optional ELEVATOR_DOOR_REOPEN_EN: a current-floor call during DOOR restarts the dwell.
module elevator_status_encoder #(
  parameter int FLOORS        = 4,
  parameter int FLOOR_W       = 2,
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 6
) (
  input logic clk,
  input logic rst,
  elevator_status_encoder_if.slave bus
);
  localparam int TW = $clog2(TRAVEL_CYCLES);
  localparam int DW = $clog2(DOOR_CYCLES);
  localparam logic [FLOOR_W-1:0] TOP = FLOOR_W'(FLOORS - 1);

  typedef enum logic [2:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR, EMERG} state_t;

  state_t             state_reg, state_next;
  logic [FLOOR_W-1:0] floor_reg, floor_next, floor_up, floor_dn;
  logic [FLOORS-1:0]  pending_reg, pending_next, req;
  logic [FLOORS-1:0]  above_cur, below_cur, here_cur, above_up, here_up, below_dn, here_dn;
  logic               dir_up_reg, dir_up_next;
  logic [TW-1:0]      travel_reg, travel_next;
  logic [DW-1:0]      door_reg, door_next;
  logic               serve;
  logic               q1_reg, q0_reg, motor_up_reg, motor_down_reg, door_open_reg;
`ifdef ELEVATOR_DOOR_REOPEN_EN
  logic               call_here;
  assign call_here = |(bus.call & (FLOORS'(1) << floor_reg));
`endif

  assign req      = pending_reg | bus.call;
  assign floor_up = (floor_reg == TOP) ? floor_reg : floor_reg + 1'b1;
  assign floor_dn = (floor_reg == '0) ? floor_reg : floor_reg - 1'b1;

  // Per-floor request comparisons against the current floor and both neighbours.
  generate
    for (genvar gi = 0; gi < FLOORS; gi++) begin : g_cmp
      localparam logic [FLOOR_W-1:0] IDX = FLOOR_W'(gi);
      assign above_cur[gi] = req[gi] && (IDX > floor_reg);
      assign below_cur[gi] = req[gi] && (IDX < floor_reg);
      assign here_cur[gi]  = req[gi] && (IDX == floor_reg);
      assign above_up[gi]  = req[gi] && (IDX > floor_up);
      assign here_up[gi]   = req[gi] && (IDX == floor_up);
      assign below_dn[gi]  = req[gi] && (IDX < floor_dn);
      assign here_dn[gi]   = req[gi] && (IDX == floor_dn);
    end
  endgenerate

  always_comb begin
    state_next  = state_reg;
    floor_next  = floor_reg;
    dir_up_next = dir_up_reg;
    travel_next = travel_reg;
    door_next   = door_reg;
    serve       = 1'b0;
    case (state_reg)
      IDLE: begin
        travel_next = '0;
        door_next   = '0;
        if (|here_cur) begin
          state_next = DOOR;
          serve      = 1'b1;
        end else if (|above_cur && (!(|below_cur) || dir_up_reg)) begin
          state_next  = MOVE_UP;
          dir_up_next = 1'b1;
        end else if (|below_cur) begin
          state_next  = MOVE_DOWN;
          dir_up_next = 1'b0;
        end
      end
      MOVE_UP: begin
        dir_up_next = 1'b1;
        if (travel_reg == TW'(TRAVEL_CYCLES - 1)) begin
          travel_next = '0;
          floor_next  = floor_up;
          if (|here_up) begin
            state_next = DOOR;
            serve      = 1'b1;
          end else if (!(|above_up)) begin
            state_next = IDLE;
          end
        end else begin
          travel_next = travel_reg + 1'b1;
        end
      end
      MOVE_DOWN: begin
        dir_up_next = 1'b0;
        if (travel_reg == TW'(TRAVEL_CYCLES - 1)) begin
          travel_next = '0;
          floor_next  = floor_dn;
          if (|here_dn) begin
            state_next = DOOR;
            serve      = 1'b1;
          end else if (!(|below_dn)) begin
            state_next = IDLE;
          end
        end else begin
          travel_next = travel_reg + 1'b1;
        end
      end
      DOOR: begin
`ifdef ELEVATOR_DOOR_REOPEN_EN
        if (call_here) begin
          door_next = '0;
          serve     = 1'b1;
        end else if (door_reg == DW'(DOOR_CYCLES - 1)) begin
          state_next = IDLE;
          door_next  = '0;
        end else begin
          door_next = door_reg + 1'b1;
        end
`else
        if (door_reg == DW'(DOOR_CYCLES - 1)) begin
          state_next = IDLE;
          door_next  = '0;
        end else begin
          door_next = door_reg + 1'b1;
        end
`endif
      end
      EMERG: begin
        if (!bus.emerg) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Emergency overrides any arrival or departure decided above.
    if (bus.emerg) begin
      state_next  = EMERG;
      floor_next  = floor_reg;
      dir_up_next = dir_up_reg;
      travel_next = '0;
      door_next   = '0;
    end
    if (bus.emerg || state_reg == EMERG) begin
      pending_next = '0;
    end else begin
      pending_next = req & ~(serve ? (FLOORS'(1) << floor_next) : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      floor_reg      <= '0;
      pending_reg    <= '0;
      dir_up_reg     <= 1'b1;
      travel_reg     <= '0;
      door_reg       <= '0;
      q1_reg         <= 1'b0;
      q0_reg         <= 1'b0;
      motor_up_reg   <= 1'b0;
      motor_down_reg <= 1'b0;
      door_open_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      floor_reg      <= floor_next;
      pending_reg    <= pending_next;
      dir_up_reg     <= dir_up_next;
      travel_reg     <= travel_next;
      door_reg       <= door_next;
      q1_reg         <= (state_next == MOVE_DOWN) || (state_next == EMERG);
      q0_reg         <= (state_next == MOVE_UP) || (state_next == EMERG);
      motor_up_reg   <= (state_next == MOVE_UP);
      motor_down_reg <= (state_next == MOVE_DOWN);
      door_open_reg  <= (state_next == DOOR);
    end
  end

  assign bus.Q1         = q1_reg;
  assign bus.Q0         = q0_reg;
  assign bus.motor_up   = motor_up_reg;
  assign bus.motor_down = motor_down_reg;
  assign bus.door_open  = door_open_reg;
  assign bus.floor      = floor_reg;
  assign bus.pending    = pending_reg;
endmodule

// File: tb/tb_elevator_status_encoder.sv
// Scenario bench for elevator_status_encoder: directed scenarios plus random traffic,
// each cycle compared against a countdown-timer car model.
module tb_elevator_status_encoder;
  localparam int FLOORS        = 4;
  localparam int FLOOR_W       = 2;
  localparam int TRAVEL_CYCLES = 8;
  localparam int DOOR_CYCLES   = 6;
  localparam int VW            = 5 + FLOOR_W + FLOORS;

  localparam int M_IDLE = 0, M_UP = 1, M_DN = 2, M_DOOR = 3, M_EM = 4;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  // Car model: mode, position, remaining cycles of the current activity.
  int m_mode;
  int m_floor;
  int m_timer;
  bit m_pref_up;
  bit m_pend [FLOORS];
  bit m_req  [FLOORS];

  always #5 clk = ~clk;

  elevator_status_encoder_if #(.FLOORS(FLOORS), .FLOOR_W(FLOOR_W)) bus ();

  elevator_status_encoder #(
    .FLOORS(FLOORS), .FLOOR_W(FLOOR_W),
    .TRAVEL_CYCLES(TRAVEL_CYCLES), .DOOR_CYCLES(DOOR_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [VW-1:0] dut_vec();
    return {bus.Q1, bus.Q0, bus.motor_up, bus.motor_down, bus.door_open, bus.floor, bus.pending};
  endfunction

  function automatic logic [VW-1:0] model_vec();
    logic [FLOORS-1:0] p;
    logic [1:0]        q;
    for (int i = 0; i < FLOORS; i++) p[i] = m_pend[i];
    case (m_mode)
      M_UP:    q = 2'b01;
      M_DN:    q = 2'b10;
      M_EM:    q = 2'b11;
      default: q = 2'b00;
    endcase
    return {q, m_mode == M_UP, m_mode == M_DN, m_mode == M_DOOR, FLOOR_W'(m_floor), p};
  endfunction

  function automatic bit beyond(int f, bit up);
    bit any = 0;
    for (int i = 0; i < FLOORS; i++)
      if (m_req[i] && (up ? (i > f) : (i < f))) any = 1;
    return any;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_floor = 0; m_timer = 0; m_pref_up = 1;
    for (int i = 0; i < FLOORS; i++) m_pend[i] = 0;
  endtask

  task automatic enter_door();
    m_mode = M_DOOR;
    m_timer = DOOR_CYCLES;
    m_pend[m_floor] = 0;
  endtask

  task automatic model_edge(input logic [FLOORS-1:0] c, input logic e);
    for (int i = 0; i < FLOORS; i++) m_req[i] = m_pend[i] | c[i];
    if (e) begin
      m_mode = M_EM; m_timer = 0;
      for (int i = 0; i < FLOORS; i++) m_pend[i] = 0;
    end else if (m_mode == M_EM) begin
      m_mode = M_IDLE;
    end else begin
      for (int i = 0; i < FLOORS; i++) m_pend[i] = m_req[i];
      case (m_mode)
        M_IDLE: begin
          if (m_req[m_floor]) enter_door();
          else if (beyond(m_floor, 1) && (!beyond(m_floor, 0) || m_pref_up)) begin
            m_mode = M_UP; m_timer = TRAVEL_CYCLES; m_pref_up = 1;
          end else if (beyond(m_floor, 0)) begin
            m_mode = M_DN; m_timer = TRAVEL_CYCLES; m_pref_up = 0;
          end
        end
        M_UP, M_DN: begin
          m_timer--;
          if (m_timer == 0) begin
            bit up;
            up = (m_mode == M_UP);
            if (up) m_floor = (m_floor < FLOORS - 1) ? m_floor + 1 : m_floor;
            else    m_floor = (m_floor > 0) ? m_floor - 1 : m_floor;
            if (m_req[m_floor]) enter_door();
            else if (beyond(m_floor, up)) m_timer = TRAVEL_CYCLES;
            else m_mode = M_IDLE;
          end
        end
        M_DOOR: begin
`ifdef ELEVATOR_DOOR_REOPEN_EN
          if (c[m_floor]) begin
            m_timer = DOOR_CYCLES;
            m_pend[m_floor] = 0;
          end else begin
            m_timer--;
            if (m_timer == 0) m_mode = M_IDLE;
          end
`else
          m_timer--;
          if (m_timer == 0) m_mode = M_IDLE;
`endif
        end
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [FLOORS-1:0] c);
    @(negedge clk);
    rst = r; bus.emerg = e; bus.call = c;
    @(posedge clk);
    if (r) model_reset(); else model_edge(c, e);
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, '0);
    step(1, 0, 4'b1111);
    vectors++;
    if (dut_vec() !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got %h expected %h", dut_vec(), {VW{1'b0}});
    end
    step(0, 0, '0);
    vectors++;
    if (dut_vec() !== model_vec()) begin
      miscompares++;
      $display("FAIL reset_idle: got %h expected %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_up_travel();
    int up_n = 0, door_n = 0;
    step(0, 0, 4'b0100);
    vectors++;
    if ({bus.Q1, bus.Q0} !== 2'b01) begin
      miscompares++;
      $display("FAIL up_start_status: got %b expected 01", {bus.Q1, bus.Q0});
    end
    up_n += int'(bus.motor_up);
    for (int n = 0; n < 29; n++) begin
      step(0, 0, '0);
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL up_travel cycle %0d: got %h expected %h", n, dut_vec(), model_vec());
      end
      if (n == 7) begin
        vectors++;
        if (bus.floor !== 2'd1) begin
          miscompares++;
          $display("FAIL up_first_floor: got %0d expected 1", bus.floor);
        end
      end
      up_n += int'(bus.motor_up);
      door_n += int'(bus.door_open);
    end
    vectors++;
    if (up_n != 16 || door_n != 6 || bus.floor !== 2'd2 || bus.pending !== 4'b0000) begin
      miscompares++;
      $display("FAIL up_summary: up=%0d door=%0d floor=%0d pend=%b expected 16 6 2 0000",
               up_n, door_n, bus.floor, bus.pending);
    end
  endtask

  task automatic test_scan();
    int up_n = 0, dn_n = 0, door_n = 0;
    for (int n = 0; n < 50; n++) begin
      step(0, 0, (n == 0) ? 4'b1001 : 4'b0000);
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL scan cycle %0d: got %h expected %h", n, dut_vec(), model_vec());
      end
      if (bus.motor_down === 1'b1 && {bus.Q1, bus.Q0} !== 2'b10) begin
        vectors++;
        miscompares++;
        $display("FAIL scan_down_status: got %b expected 10", {bus.Q1, bus.Q0});
      end
      up_n += int'(bus.motor_up);
      dn_n += int'(bus.motor_down);
      door_n += int'(bus.door_open);
    end
    vectors++;
    if (up_n != 8 || dn_n != 24 || door_n != 12 || bus.floor !== 2'd0) begin
      miscompares++;
      $display("FAIL scan_summary: up=%0d down=%0d door=%0d floor=%0d expected 8 24 12 0",
               up_n, dn_n, door_n, bus.floor);
    end
  endtask

  task automatic test_current_floor();
    int door_n = 0, motor_n = 0, pend_n = 0;
    for (int n = 0; n < 10; n++) begin
      step(0, 0, (n == 0) ? 4'b0001 : 4'b0000);
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL current_floor cycle %0d: got %h expected %h", n, dut_vec(), model_vec());
      end
      if (n == 0) begin
        vectors++;
        if (bus.door_open !== 1'b1) begin
          miscompares++;
          $display("FAIL current_floor_latency: door_open=%b expected 1", bus.door_open);
        end
      end
      door_n  += int'(bus.door_open);
      motor_n += int'(bus.motor_up) + int'(bus.motor_down);
      pend_n  += int'(bus.pending[0]);
    end
    vectors++;
    if (door_n != 6 || motor_n != 0 || pend_n != 0) begin
      miscompares++;
      $display("FAIL current_floor_summary: door=%0d motor=%0d pend=%0d expected 6 0 0",
               door_n, motor_n, pend_n);
    end
  endtask

  task automatic test_emerg();
    for (int n = 0; n < 20; n++) begin
      logic e;
      logic [FLOORS-1:0] c;
      e = (n >= 12 && n <= 14);
      c = (n == 0) ? 4'b0100 : ((n >= 12 && n <= 15) ? 4'($urandom_range(1, 15)) : 4'b0000);
      step(0, e, c);
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL emerg cycle %0d: got %h expected %h", n, dut_vec(), model_vec());
      end
      if (e) begin
        vectors++;
        if ({bus.Q1, bus.Q0, bus.motor_up, bus.motor_down, bus.door_open} !== 5'b11000 ||
            bus.pending !== 4'b0000) begin
          miscompares++;
          $display("FAIL emerg_hold: Q/motors/door=%b pend=%b expected 11000 0000",
                   {bus.Q1, bus.Q0, bus.motor_up, bus.motor_down, bus.door_open}, bus.pending);
        end
      end
      if (n == 15) begin
        vectors++;
        if ({bus.Q1, bus.Q0} !== 2'b00 || bus.floor !== 2'd1 || bus.pending !== 4'b0000) begin
          miscompares++;
          $display("FAIL emerg_release: Q=%b floor=%0d pend=%b expected 00 1 0000",
                   {bus.Q1, bus.Q0}, bus.floor, bus.pending);
        end
      end
    end
  endtask

  task automatic test_reset_mid_door();
    for (int n = 0; n < 3; n++) begin
      step(0, 0, (n == 0) ? 4'b0010 : 4'b0000);
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL door_before_reset cycle %0d: got %h expected %h", n, dut_vec(), model_vec());
      end
    end
    step(1, 0, 4'b0100);
    vectors++;
    if (dut_vec() !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_door: got %h expected %h", dut_vec(), {VW{1'b0}});
    end
    step(0, 0, '0);
  endtask

  task automatic test_door_reopen();
    int door_n = 0, dwell_n = 0;
    logic prev = 1'b0;
    for (int n = 0; n < 25; n++) begin
      step(0, 0, (n == 0 || n == 4) ? 4'b0001 : 4'b0000);
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL door_reopen cycle %0d: got %h expected %h", n, dut_vec(), model_vec());
      end
      door_n += int'(bus.door_open);
      if (bus.door_open === 1'b1 && !prev) dwell_n++;
      prev = bus.door_open;
    end
    vectors++;
`ifdef ELEVATOR_DOOR_REOPEN_EN
    if (door_n != 10 || dwell_n != 1) begin
      miscompares++;
      $display("FAIL door_reopen_summary: door=%0d dwells=%0d expected 10 1", door_n, dwell_n);
    end
`else
    if (door_n != 12 || dwell_n != 2) begin
      miscompares++;
      $display("FAIL door_reopen_summary: door=%0d dwells=%0d expected 12 2", door_n, dwell_n);
    end
`endif
  endtask

  task automatic test_random();
    int e_hold = 0;
    for (int n = 0; n < 3000; n++) begin
      logic r, e;
      logic [FLOORS-1:0] c;
      r = ($urandom_range(0, 599) == 0);
      if (e_hold == 0 && $urandom_range(0, 149) == 0) e_hold = $urandom_range(1, 4);
      e = (e_hold > 0);
      if (e_hold > 0) e_hold--;
      c = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      step(r, e, c);
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL random cycle %0d: got %h expected %h (rst=%b emerg=%b call=%b)",
                 n, dut_vec(), model_vec(), r, e, c);
      end
      if (bus.door_open === 1'b1 && (bus.motor_up === 1'b1 || bus.motor_down === 1'b1)) begin
        vectors++;
        miscompares++;
        $display("FAIL door_with_motor cycle %0d: door=%b up=%b down=%b expected no overlap",
                 n, bus.door_open, bus.motor_up, bus.motor_down);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.emerg = 1'b0;
    bus.call = '0;
    model_reset();
    test_reset();
    test_up_travel();
    test_scan();
    test_current_floor();
    test_emerg();
    test_reset_mid_door();
    test_door_reopen();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
